// File: rtl/vga_capture_pkg.sv
// Shared constants, stage payload type and the NES RGB888 palette for the VGA capture path.
package vga_capture_pkg;

   localparam int unsigned H_START_DEF = 64;
   localparam int unsigned H_WIDTH_DEF = 512;
   localparam int unsigned V_LINES_DEF = 480;
   localparam int unsigned NES_W       = 256;
   localparam int unsigned NES_H       = 240;
   localparam int unsigned CNT_W       = 10;
   localparam int unsigned AGE_W       = 11;
   localparam int unsigned CRD_W       = 9;
   localparam int unsigned IDX_W       = 6;
   localparam int unsigned RGB_W       = 24;
   localparam int unsigned PAL_N       = 64;

   localparam logic [IDX_W-1:0] NOMATCH_IDX = 6'h0D;

   // Stage-1 sample handed to the palette lookup stage
   typedef struct packed {
      logic             valid;
      logic [CRD_W-1:0] hcnt;
      logic [CRD_W-1:0] vcnt;
      logic [RGB_W-1:0] rgb;
   } pix_t;

   // NES palette, same table the scan-out path drives onto the VGA pins
   function automatic logic [RGB_W-1:0] nes_rgb(input logic [IDX_W-1:0] idx);
      logic [RGB_W-1:0] c;
      case (idx)
         6'h00: c = 24'h7C7C7C;  6'h01: c = 24'h0000FC;  6'h02: c = 24'h0000BC;  6'h03: c = 24'h4428BC;
         6'h04: c = 24'h940084;  6'h05: c = 24'hA80020;  6'h06: c = 24'hA81000;  6'h07: c = 24'h881400;
         6'h08: c = 24'h503000;  6'h09: c = 24'h007800;  6'h0A: c = 24'h006800;  6'h0B: c = 24'h005800;
         6'h0C: c = 24'h004058;  6'h0D: c = 24'h000000;  6'h0E: c = 24'h000000;  6'h0F: c = 24'h000000;
         6'h10: c = 24'hBCBCBC;  6'h11: c = 24'h0078F8;  6'h12: c = 24'h0058F8;  6'h13: c = 24'h6844FC;
         6'h14: c = 24'hD800CC;  6'h15: c = 24'hE40058;  6'h16: c = 24'hF83800;  6'h17: c = 24'hE45C10;
         6'h18: c = 24'hAC7C00;  6'h19: c = 24'h00B800;  6'h1A: c = 24'h00A800;  6'h1B: c = 24'h00A844;
         6'h1C: c = 24'h008888;  6'h1D: c = 24'h000000;  6'h1E: c = 24'h000000;  6'h1F: c = 24'h000000;
         6'h20: c = 24'hF8F8F8;  6'h21: c = 24'h3CBCFC;  6'h22: c = 24'h6888FC;  6'h23: c = 24'h9878F8;
         6'h24: c = 24'hF878F8;  6'h25: c = 24'hF85898;  6'h26: c = 24'hF87858;  6'h27: c = 24'hFCA044;
         6'h28: c = 24'hF8B800;  6'h29: c = 24'hB8F818;  6'h2A: c = 24'h58D854;  6'h2B: c = 24'h58F898;
         6'h2C: c = 24'h00E8D8;  6'h2D: c = 24'h787878;  6'h2E: c = 24'h000000;  6'h2F: c = 24'h000000;
         6'h30: c = 24'hFCFCFC;  6'h31: c = 24'hA4E4FC;  6'h32: c = 24'hB8B8F8;  6'h33: c = 24'hD8B8F8;
         6'h34: c = 24'hF8B8F8;  6'h35: c = 24'hF8A4C0;  6'h36: c = 24'hF0D0B0;  6'h37: c = 24'hFCE0A8;
         6'h38: c = 24'hF8D878;  6'h39: c = 24'hD8F878;  6'h3A: c = 24'hB8F8B8;  6'h3B: c = 24'hB8F8D8;
         6'h3C: c = 24'h00FCFC;  6'h3D: c = 24'hF8D8F8;  6'h3E: c = 24'h000000;  default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_capture_if.sv
// VGA input bundle and NES pixel stream output of the frame grabber.
interface vga_capture_if;
   import vga_capture_pkg::*;

   logic             I_HSYNC;
   logic             I_VSYNC;
   logic             I_BLANK;
   logic [7:0]       I_RED;
   logic [7:0]       I_GREEN;
   logic [7:0]       I_BLUE;
   logic [IDX_W-1:0] O_COLOR;
   logic [CRD_W-1:0] O_HCNT;
   logic [CRD_W-1:0] O_VCNT;
   logic             O_VALID;
   logic             O_NOMATCH;
   logic             O_FRAME_START;

   // Video source side
   modport master (
      output I_HSYNC, I_VSYNC, I_BLANK, I_RED, I_GREEN, I_BLUE,
      input  O_COLOR, O_HCNT, O_VCNT, O_VALID, O_NOMATCH, O_FRAME_START
   );

   // Capture side
   modport slave (
      input  I_HSYNC, I_VSYNC, I_BLANK, I_RED, I_GREEN, I_BLUE,
      output O_COLOR, O_HCNT, O_VCNT, O_VALID, O_NOMATCH, O_FRAME_START
   );

endinterface

// File: rtl/vga_capture_palette_rev.sv
// Reverse palette lookup: exact RGB888 match to a 6-bit NES index, registered.
module nes_palette_rev
   import vga_capture_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [RGB_W-1:0] rgb_i,
   output logic [IDX_W-1:0] color_o,
   output logic             nomatch_o
);

   logic [IDX_W-1:0] color_d, color_q;
   logic             nomatch_d, nomatch_q;

   // Scan high to low so the lowest matching index is the one that sticks
   always_comb begin
      color_d   = NOMATCH_IDX;
      nomatch_d = 1'b1;
      for (int i = int'(PAL_N) - 1; i >= 0; i--) begin
         if (rgb_i == nes_rgb(6'(i))) begin
            color_d   = 6'(i);
            nomatch_d = 1'b0;
         end
      end
   end

   // Output register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         color_q   <= '0;
         nomatch_q <= 1'b0;
      end else begin
         color_q   <= color_d;
         nomatch_q <= nomatch_d;
      end
   end

   assign color_o   = color_q;
   assign nomatch_o = nomatch_q;

endmodule

// File: rtl/vga_capture.sv
// VGA frame grabber: sync tracking, 2x2 decimation of the picture window, reverse palette map.
module vga_capture
   import vga_capture_pkg::*;
#(
   parameter int unsigned H_START  = H_START_DEF,
   parameter int unsigned H_WIDTH  = H_WIDTH_DEF,
   parameter int unsigned V_LINES  = V_LINES_DEF,
   parameter bit          SYNC_ACT = 1'b0
) (
   input  logic          I_CLK,
   input  logic          I_RESET_N,
   vga_capture_if.slave  vif
);

   // Registered inputs; sync kept as "active" flags so polarity is handled once
   logic             hs_act_q, hs_act_d1_q;
   logic             vs_act_q, vs_act_d1_q;
   logic             blank_q, blank_d1_q;
   logic [RGB_W-1:0] rgb_q;

   logic [CNT_W-1:0] x_q, x_d, x_cur, x_off;
   logic [CNT_W-1:0] y_q, y_d;
   logic [AGE_W-1:0] hs_age_q, hs_age_d;
   logic             armed_q, armed_d;
   logic             hs_edge, vs_edge, blank_rise, in_win;

   pix_t             st1_d, st1_q;
   logic             valid_q, frame_start_q;
   logic [CRD_W-1:0] hcnt_q, vcnt_q;

   // Input sampling; sync flags reset to "active" so a held sync gives no false edge
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         hs_act_q    <= 1'b1;
         hs_act_d1_q <= 1'b1;
         vs_act_q    <= 1'b1;
         vs_act_d1_q <= 1'b1;
         blank_q     <= 1'b1;
         blank_d1_q  <= 1'b1;
         rgb_q       <= '0;
      end else begin
         hs_act_q    <= (vif.I_HSYNC == SYNC_ACT);
         hs_act_d1_q <= hs_act_q;
         vs_act_q    <= (vif.I_VSYNC == SYNC_ACT);
         vs_act_d1_q <= vs_act_q;
         blank_q     <= vif.I_BLANK;
         blank_d1_q  <= blank_q;
         rgb_q       <= {vif.I_RED, vif.I_GREEN, vif.I_BLUE};
      end
   end

   // Edge detect, x/y counters, HSYNC lock age, arming and stage-1 capture decision
   always_comb begin
      hs_edge    = hs_act_q & ~hs_act_d1_q;
      vs_edge    = vs_act_q & ~vs_act_d1_q;
      blank_rise = blank_q & ~blank_d1_q;

      x_cur = blank_d1_q ? '0 : ((x_q == '1) ? x_q : x_q + 10'd1);
      x_d   = blank_q ? x_q : x_cur;

      y_d = y_q;
      if (vs_edge)
         y_d = '0;
      else if (blank_rise && (y_q != '1))
         y_d = y_q + 10'd1;

      hs_age_d = hs_edge ? '0 : ((hs_age_q == '1) ? hs_age_q : hs_age_q + 11'd1);

      // Arm only if HSYNC toggled within the last 1024 cycles
      armed_d = armed_q;
      if (vs_edge)
         armed_d = hs_edge || (hs_age_q <= 11'd1023);

      x_off  = x_cur - 10'(H_START);
      in_win = armed_q && !blank_q
               && (x_cur >= 10'(H_START)) && (x_cur < 10'(H_START + H_WIDTH))
               && !x_off[0]
               && (y_q < 10'(V_LINES)) && !y_q[0];

      st1_d       = '0;
      st1_d.valid = in_win;
      st1_d.hcnt  = 9'(x_off >> 1);
      st1_d.vcnt  = 9'(y_q >> 1);
      st1_d.rgb   = rgb_q;
   end

   // Counter, arming and stage-1 state
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         x_q      <= '0;
         y_q      <= '0;
         hs_age_q <= '1;
         armed_q  <= 1'b0;
         st1_q    <= '0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         hs_age_q <= hs_age_d;
         armed_q  <= armed_d;
         st1_q    <= st1_d;
      end
   end

   // Stage 2: coordinates and strobe travel alongside the palette lookup
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         valid_q       <= 1'b0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         frame_start_q <= 1'b0;
      end else begin
         valid_q       <= st1_q.valid;
         hcnt_q        <= st1_q.hcnt;
         vcnt_q        <= st1_q.vcnt;
         frame_start_q <= vs_edge;
      end
   end

   nes_palette_rev u_pal (
      .clk_i     (I_CLK),
      .rst_ni    (I_RESET_N),
      .rgb_i     (st1_q.rgb),
      .color_o   (vif.O_COLOR),
      .nomatch_o (vif.O_NOMATCH)
   );

   assign vif.O_VALID       = valid_q;
   assign vif.O_HCNT        = hcnt_q;
   assign vif.O_VCNT        = vcnt_q;
   assign vif.O_FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench: default-size grabber for coordinates/colours, two small-window grabbers
// (one per sync polarity) for whole-frame counts and mid-frame reset.
module tb_vga_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hs_lvl = 1'b1;
   logic        vs_lvl = 1'b1;
   logic        blank = 1'b1;
   logic [23:0] rgb = '0;

   int unsigned cyc = 0;
   int unsigned tag_cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   localparam logic [23:0] GREY = 24'h7C7C7C;
   localparam logic [23:0] RED  = 24'hF83800;

   typedef struct {
      logic [8:0]  h;
      logic [8:0]  v;
      logic [5:0]  c;
      logic        nm;
      int unsigned cyc;
   } rec_t;

   rec_t qd[$];
   int   fs_cnt = 0;
   int   s0_cnt = 0, s0_h = 0, s0_v = 0, s0_bad = 0;
   int   s1_cnt = 0, s1_h = 0, s1_v = 0, s1_bad = 0;

   vga_capture_if if_d ();
   vga_capture_if if_s0 ();
   vga_capture_if if_s1 ();

   assign if_d.I_HSYNC  = hs_lvl;
   assign if_d.I_VSYNC  = vs_lvl;
   assign if_d.I_BLANK  = blank;
   assign if_d.I_RED    = rgb[23:16];
   assign if_d.I_GREEN  = rgb[15:8];
   assign if_d.I_BLUE   = rgb[7:0];
   assign if_s0.I_HSYNC = hs_lvl;
   assign if_s0.I_VSYNC = vs_lvl;
   assign if_s0.I_BLANK = blank;
   assign if_s0.I_RED   = rgb[23:16];
   assign if_s0.I_GREEN = rgb[15:8];
   assign if_s0.I_BLUE  = rgb[7:0];
   assign if_s1.I_HSYNC = ~hs_lvl;
   assign if_s1.I_VSYNC = ~vs_lvl;
   assign if_s1.I_BLANK = blank;
   assign if_s1.I_RED   = rgb[23:16];
   assign if_s1.I_GREEN = rgb[15:8];
   assign if_s1.I_BLUE  = rgb[7:0];

   vga_capture dut (.I_CLK(clk), .I_RESET_N(rst_n), .vif(if_d));
   vga_capture #(.H_START(4), .H_WIDTH(16), .V_LINES(8), .SYNC_ACT(1'b0))
      dut_s0 (.I_CLK(clk), .I_RESET_N(rst_n), .vif(if_s0));
   vga_capture #(.H_START(4), .H_WIDTH(16), .V_LINES(8), .SYNC_ACT(1'b1))
      dut_s1 (.I_CLK(clk), .I_RESET_N(rst_n), .vif(if_s1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (if_d.O_VALID)
         qd.push_back('{h: if_d.O_HCNT, v: if_d.O_VCNT, c: if_d.O_COLOR, nm: if_d.O_NOMATCH, cyc: cyc});
      if (if_d.O_FRAME_START) fs_cnt++;
      if (if_s0.O_VALID) begin
         s0_cnt++; s0_h += int'(if_s0.O_HCNT); s0_v += int'(if_s0.O_VCNT);
         if (if_s0.O_COLOR != 6'h00 || if_s0.O_NOMATCH) s0_bad++;
      end
      if (if_s1.O_VALID) begin
         s1_cnt++; s1_h += int'(if_s1.O_HCNT); s1_v += int'(if_s1.O_VCNT);
         if (if_s1.O_COLOR != 6'h00 || if_s1.O_NOMATCH) s1_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_rec(input string tag, input int idx, input int h, input int v,
                          input int c, input int nm);
      if (idx < 0 || idx >= qd.size()) begin
         check({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_hcnt"}, 32'(qd[idx].h), 32'(h));
         check({tag, "_vcnt"}, 32'(qd[idx].v), 32'(v));
         check({tag, "_color"}, 32'(qd[idx].c), 32'(c));
         check({tag, "_nomatch"}, 32'(qd[idx].nm), 32'(nm));
      end
   endtask

   // One input cycle; sync arguments are logical "active" (default active-low wiring)
   task automatic drive(input logic hs_a, input logic vs_a, input logic bl, input logic [23:0] px);
      hs_lvl = ~hs_a;
      vs_lvl = ~vs_a;
      blank  = bl;
      rgb    = px;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b1, 24'h0);
   endtask

   // Two blank cycles (HSYNC in the first) then n active pixels; pixel sx gets srgb
   task automatic line(input int n, input logic [23:0] base, input int sx, input logic [23:0] srgb);
      drive(1'b1, 1'b0, 1'b1, 24'h0);
      drive(1'b0, 1'b0, 1'b1, 24'h0);
      for (int x = 0; x < n; x++) begin
         if (x == sx) tag_cyc = cyc + 1;
         drive(1'b0, 1'b0, 1'b0, (x == sx) ? srgb : base);
      end
   endtask

   task automatic vsync_pulse(input logic with_hs);
      drive(with_hs, 1'b1, 1'b1, 24'h0);
      drive(1'b0, 1'b1, 1'b1, 24'h0);
      drive(1'b0, 1'b1, 1'b1, 24'h0);
      drive(1'b0, 1'b0, 1'b1, 24'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, f, b0, b1;
      repeat (3) @(negedge clk);
      check("rst_valid",  32'(if_d.O_VALID), 0);
      check("rst_color",  32'(if_d.O_COLOR), 0);
      check("rst_hcnt",   32'(if_d.O_HCNT), 0);
      check("rst_vcnt",   32'(if_d.O_VCNT), 0);
      check("rst_nomatch", 32'(if_d.O_NOMATCH), 0);
      check("rst_fs",     32'(if_d.O_FRAME_START), 0);
      rst_n = 1'b1;
      idle(4);

      // No VSYNC since reset: nothing captured, then the first VSYNC edge pulses once
      s = qd.size();
      repeat (4) line(100, GREY, -1, 24'h0);
      idle(4);
      check("unarmed_valids", 32'(qd.size() - s), 0);
      f = fs_cnt;
      vsync_pulse(1'b1);
      check("fs_one_cycle", 32'(fs_cnt - f), 1);

      // Default window: y=0..480 after the VSYNC edge
      for (int y = 0; y < 6; y++) line(10, GREY, -1, 24'h0);
      s = qd.size();
      line(75, GREY, 74, RED);
      idle(4);
      check("row6_count", 32'(qd.size() - s), 6);
      chk_rec("row6_first", s, 0, 3, 6'h00, 0);
      chk_rec("row6_x74", s + 5, 5, 3, 6'h16, 0);
      if (qd.size() >= s + 6) check("row6_latency", qd[s + 5].cyc - tag_cyc, 2);
      s = qd.size();
      line(75, GREY, -1, 24'h0);
      idle(4);
      check("row7_odd_dropped", 32'(qd.size() - s), 0);
      s = qd.size();
      line(67, 24'h123456, 64, 24'h000000);
      idle(4);
      check("row8_count", 32'(qd.size() - s), 2);
      chk_rec("black", s, 0, 4, 6'h0D, 0);
      chk_rec("nomatch", s + 1, 1, 4, 6'h0D, 1);
      for (int y = 9; y < 478; y++) line(10, GREY, -1, 24'h0);
      s = qd.size();
      line(577, GREY, 574, RED);
      idle(4);
      check("row478_count", 32'(qd.size() - s), 256);
      chk_rec("row478_first", s, 0, 239, 6'h00, 0);
      chk_rec("row478_last", s + 255, 255, 239, 6'h16, 0);
      s = qd.size();
      line(10, GREY, -1, 24'h0);
      line(577, GREY, -1, 24'h0);
      idle(4);
      check("row480_ignored", 32'(qd.size() - s), 0);

      // VSYNC without recent HSYNC disarms; a locked VSYNC re-arms
      idle(1100);
      f = fs_cnt;
      s = qd.size();
      vsync_pulse(1'b0);
      line(70, GREY, -1, 24'h0);
      idle(4);
      check("nolock_fs", 32'(fs_cnt - f), 1);
      check("nolock_valids", 32'(qd.size() - s), 0);
      s = qd.size();
      vsync_pulse(1'b1);
      line(70, GREY, -1, 24'h0);
      idle(4);
      check("relock_count", 32'(qd.size() - s), 3);
      chk_rec("relock_last", s + 2, 2, 0, 6'h00, 0);

      // Small-window grabbers: reset mid-frame, then one full frame of grey
      vsync_pulse(1'b1);
      repeat (3) line(20, GREY, -1, 24'h0);
      drive(1'b1, 1'b0, 1'b1, 24'h0);
      drive(1'b0, 1'b0, 1'b1, 24'h0);
      rst_n = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 1'b0, GREY);
      rst_n = 1'b1;
      repeat (10) drive(1'b0, 1'b0, 1'b0, GREY);
      b0 = s0_cnt;
      b1 = s1_cnt;
      repeat (3) line(20, GREY, -1, 24'h0);
      idle(4);
      check("s0_after_reset", 32'(s0_cnt - b0), 0);
      check("s1_after_reset", 32'(s1_cnt - b1), 0);
      b0 = s0_cnt; s0_h = 0; s0_v = 0; s0_bad = 0;
      b1 = s1_cnt; s1_h = 0; s1_v = 0; s1_bad = 0;
      vsync_pulse(1'b1);
      for (int y = 0; y < 10; y++) line(20, GREY, -1, 24'h0);
      idle(4);
      check("s0_frame_count", 32'(s0_cnt - b0), 32);
      check("s0_hsum", 32'(s0_h), 112);
      check("s0_vsum", 32'(s0_v), 48);
      check("s0_bad_color", 32'(s0_bad), 0);
      check("s1_frame_count", 32'(s1_cnt - b1), 32);
      check("s1_hsum", 32'(s1_h), 112);
      check("s1_vsum", 32'(s1_v), 48);
      check("s1_bad_color", 32'(s1_bad), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
